// File: rtl/myfilter_pkg.sv
// ----------------------------------------------------------------------------
// myfilter_pkg
// Shared constants and types for the filter configuration block.
//   CFG_WORDS_DEF : default number of configuration words
//   WORD_W_DEF    : default configuration word width in bits
//   cfg_state_t   : frame-tracking FSM states
//   cfg_word_t    : packed array of configuration words, index 0 = word 0
// ----------------------------------------------------------------------------
package myfilter_pkg;

  localparam int CFG_WORDS_DEF = 4;
  localparam int WORD_W_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } cfg_state_t;

  typedef logic [CFG_WORDS_DEF-1:0][WORD_W_DEF-1:0] cfg_word_t;

endpackage : myfilter_pkg

// File: rtl/myfilter_cfg_srg.sv
// ----------------------------------------------------------------------------
// myfilter_cfg_srg
// Configuration shift register: serial shift-in at bit 0, parallel load,
// and serial readout from the MSB. Load wins over shift.
//   clk, rst_n : clock, asynchronous active-low reset
//   shift_en   : shift left one bit, sd_in entering at bit 0
//   load_en    : load load_data in parallel
//   sd_in      : serial input bit
//   load_data  : parallel load value
//   sd_out     : serial output (MSB of the register, combinational)
//   sreg       : current register contents
// ----------------------------------------------------------------------------
module myfilter_cfg_srg
  import myfilter_pkg::*;
#(
  parameter int N = CFG_WORDS_DEF * WORD_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic         load_en,
  input  logic         sd_in,
  input  logic [N-1:0] load_data,
  output logic         sd_out,
  output logic [N-1:0] sreg
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
    end else if (load_en) begin
      sreg <= load_data;
    end else if (shift_en) begin
      sreg <= {sreg[N-2:0], sd_in};
    end
  end

  assign sd_out = sreg[N-1];

endmodule : myfilter_cfg_srg

// File: rtl/myfilter_cfg.sv
// ----------------------------------------------------------------------------
// myfilter_cfg
// Serial configuration store for the filter datapath. An I2C slave shifts a
// frame in MSB-first (word 0 first); a download strobe commits the frame if
// it is exactly CFG_WORDS*WORD_W bits long, otherwise flags a length error.
// An upload strobe reloads the shift register from the committed words so
// they can be read back serially on sd_out.
//   clk, rst_n    : clock, asynchronous active-low reset
//   sde_in, sd_in : serial enable / data from the I2C slave
//   sd_out        : serial readback bit
//   dl_in, ul_in  : download (commit) / upload (reload) strobes
//   cfg_out       : committed words, cfg_out[0] = word 0
//   cfg_valid_out : one-cycle pulse after a successful commit
//   len_err_out   : sticky wrong-length flag, cleared by a good commit
// Input priority: dl_in > ul_in > sde_in.
// ----------------------------------------------------------------------------
module myfilter_cfg
  import myfilter_pkg::*;
#(
  parameter int CFG_WORDS = CFG_WORDS_DEF,
  parameter int WORD_W    = WORD_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              sde_in,
  input  logic                              sd_in,
  output logic                              sd_out,
  input  logic                              dl_in,
  input  logic                              ul_in,
  output logic [CFG_WORDS-1:0][WORD_W-1:0]  cfg_out,
  output logic                              cfg_valid_out,
  output logic                              len_err_out
);

  localparam int CFG_BITS = CFG_WORDS * WORD_W;
  // Counter must reach CFG_BITS+1 so an over-long frame stays distinguishable.
  localparam int CNT_W    = $clog2(CFG_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

  cfg_state_t          state, state_next;
  logic [CNT_W-1:0]    bcnt, bcnt_next;
  logic [CFG_BITS-1:0] sreg;
  logic [CFG_BITS-1:0] load_data;
  logic                shift_en;
  logic                load_en;
  logic                frame_ok;

  // Priority decode: a download masks upload and shift in the same cycle.
  assign load_en  = ul_in & ~dl_in;
  assign shift_en = sde_in & ~dl_in & ~ul_in;
  assign frame_ok = dl_in & (bcnt == CNT_FULL);

  // Word 0 occupies the MSBs so readback starts with its MSB.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    load_data = '0;
    for (int i = 0; i < CFG_WORDS; i++) begin
      load_data[CFG_BITS-1-i*WORD_W -: WORD_W] = cfg_out[i];
    end
  end

  myfilter_cfg_srg #(
    .N (CFG_BITS)
  ) u_srg (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (shift_en),
    .load_en   (load_en),
    .sd_in     (sd_in),
    .load_data (load_data),
    .sd_out    (sd_out),
    .sreg      (sreg)
  );

  always_comb begin
    bcnt_next = bcnt;
    if (dl_in || ul_in) begin
      bcnt_next = '0;
    end else if (sde_in && (bcnt != CNT_SAT)) begin
      bcnt_next = bcnt + 1'b1;
    end
  end

  // COMMIT lasts exactly one cycle unless another download follows; outside
  // COMMIT the state simply tracks whether any bits have been received.
  always_comb begin
    state_next = state;
    if (dl_in) begin
      state_next = COMMIT;
    end else if (state == COMMIT) begin
      state_next = IDLE;
    end else if (bcnt_next != '0) begin
      state_next = SHIFT;
    end else begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bcnt  <= '0;
    end else begin
      state <= state_next;
      bcnt  <= bcnt_next;
    end
  end

  // NOTE: cfg_out is reset even though it is wide: the datapath must see a
  // defined all-zero configuration before the first download.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_out       <= '0;
      cfg_valid_out <= 1'b0;
      len_err_out   <= 1'b0;
    end else begin
      cfg_valid_out <= frame_ok;
      if (frame_ok) begin
        for (int i = 0; i < CFG_WORDS; i++) begin
          cfg_out[i] <= sreg[CFG_BITS-1-i*WORD_W -: WORD_W];
        end
        len_err_out <= 1'b0;
      end else if (dl_in) begin
        len_err_out <= 1'b1;
      end
    end
  end

endmodule : myfilter_cfg

// File: tb/tb_myfilter_cfg.sv
// ----------------------------------------------------------------------------
// tb_myfilter_cfg
// Self-checking bench for myfilter_cfg with a behavioural reference model:
// the model keeps the frame as a 32-bit value built arithmetically, a bit
// count, the committed bytes and the error flag.
// ----------------------------------------------------------------------------
module tb_myfilter_cfg;
  import myfilter_pkg::*;

  localparam int NBITS = CFG_WORDS_DEF * WORD_W_DEF;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      sde_in, sd_in, dl_in, ul_in;
  logic      sd_out;
  cfg_word_t cfg_out;
  logic      cfg_valid_out;
  logic      len_err_out;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [NBITS-1:0] m_frame;
  int               m_cnt;
  logic [7:0]       m_cfg [CFG_WORDS_DEF];
  logic             m_valid;
  logic             m_err;

  myfilter_cfg dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sde_in        (sde_in),
    .sd_in         (sd_in),
    .sd_out        (sd_out),
    .dl_in         (dl_in),
    .ul_in         (ul_in),
    .cfg_out       (cfg_out),
    .cfg_valid_out (cfg_valid_out),
    .len_err_out   (len_err_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic cfg_word_t m_cfg_word();
    cfg_word_t w;
    for (int i = 0; i < CFG_WORDS_DEF; i++) w[i] = m_cfg[i];
    return w;
  endfunction

  task automatic model_reset();
    m_frame = '0;
    m_cnt   = 0;
    for (int i = 0; i < CFG_WORDS_DEF; i++) m_cfg[i] = 8'h00;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  // Apply the rules of one clock cycle to the model.
  task automatic model_step(input logic sde, input logic sd, input logic dl, input logic ul);
    m_valid = 1'b0;
    if (dl) begin
      if (m_cnt == NBITS) begin
        for (int i = 0; i < CFG_WORDS_DEF; i++)
          m_cfg[i] = 8'((m_frame >> (8 * (CFG_WORDS_DEF - 1 - i))) & 'hFF);
        m_valid = 1'b1;
        m_err   = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      m_cnt = 0;
    end else if (ul) begin
      m_frame = '0;
      for (int i = 0; i < CFG_WORDS_DEF; i++)
        m_frame = m_frame * 256 + NBITS'(m_cfg[i]);
      m_cnt = 0;
    end else if (sde) begin
      m_frame = m_frame * 2 + NBITS'(sd);
      m_cnt   = (m_cnt + 1 > NBITS + 1) ? NBITS + 1 : m_cnt + 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sd_out"},   64'(sd_out),        64'(m_frame[NBITS-1]));
    chk({tag, ".cfg_out"},  64'(cfg_out),       64'(m_cfg_word()));
    chk({tag, ".valid"},    64'(cfg_valid_out), 64'(m_valid));
    chk({tag, ".len_err"},  64'(len_err_out),   64'(m_err));
    chk({tag, ".bcnt"},     64'(dut.bcnt),      64'(m_cnt));
    chk({tag, ".sreg"},     64'(dut.sreg),      64'(m_frame));
  endtask

  // One clock cycle: inputs are driven away from the edge, outputs sampled #1 after it.
  task automatic step(input string tag, input logic sde, input logic sd, input logic dl, input logic ul);
    sde_in = sde; sd_in = sd; dl_in = dl; ul_in = ul;
    @(posedge clk);
    #1;
    model_step(sde, sd, dl, ul);
    check_all(tag);
    sde_in = 1'b0; sd_in = 1'b0; dl_in = 1'b0; ul_in = 1'b0;
  endtask

  task automatic send_bits(input string tag, input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, bits[i], 1'b0, 1'b0);
  endtask

  logic [31:0] rnd;
  logic [31:0] rb;

  initial begin
    rst_n = 1'b0; sde_in = 1'b0; sd_in = 1'b0; dl_in = 1'b0; ul_in = 1'b0;
    model_reset();
    #23;
    check_all("reset");
    @(negedge clk) rst_n = 1'b1;
    step("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle.state", 64'(dut.state), 64'(IDLE));

    // Good frame and commit
    send_bits("frame1", 64'hA53C0FF0, 32);
    step("commit1", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("commit1.cfg_abs", 64'(cfg_out), 64'({8'hF0, 8'h0F, 8'h3C, 8'hA5}));
    chk("commit1.state", 64'(dut.state), 64'(COMMIT));
    step("after_commit1", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("after_commit1.state", 64'(dut.state), 64'(IDLE));

    // Readback
    step("upload", 1'b0, 1'b0, 1'b0, 1'b1);
    rb = '0;
    for (int i = 0; i < 32; i++) begin
      rb = {rb[30:0], sd_out};
      step("readback", 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    chk("readback.word", 64'(rb), 64'h0000_0000_A53C_0FF0);

    // Short frame, then a good one clears the error
    rnd = $urandom;
    send_bits("short", 64'(rnd), 31);
    step("short_dl", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("short_dl.err_abs", 64'(len_err_out), 64'd1);
    rnd = $urandom;
    send_bits("good2", 64'(rnd), 32);
    step("good2_dl", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("good2_dl.err_abs", 64'(len_err_out), 64'd0);

    // dl + ul + sde together after a valid frame
    rnd = $urandom;
    send_bits("prio", 64'(rnd), 32);
    step("prio_all", 1'b1, 1'b1, 1'b1, 1'b1);
    chk("prio_all.sreg_abs", 64'(dut.sreg), 64'(rnd));

    // Partial frame then upload: no error
    send_bits("partial", 64'($urandom), 10);
    step("partial_ul", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("partial_ul.err_abs", 64'(len_err_out), 64'd0);

    // Asynchronous reset mid-frame
    send_bits("pre_rst", 64'($urandom), 12);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk) rst_n = 1'b1;
    step("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst.state", 64'(dut.state), 64'(IDLE));
    rnd = $urandom;
    send_bits("rst_frame", 64'(rnd), 32);
    step("rst_frame_dl", 1'b0, 1'b0, 1'b1, 1'b0);

    // Over-long frame: counter saturates at NBITS+1
    rnd = $urandom;
    send_bits("long", {rnd, rnd}, 40);
    chk("long.bcnt_abs", 64'(dut.bcnt), 64'd33);
    step("long_dl", 1'b0, 1'b0, 1'b1, 1'b0);

    // Random good frames
    for (int f = 0; f < 5; f++) begin
      send_bits("rframe", 64'($urandom), 32);
      step("rframe_dl", 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      step("rand",
           1'($urandom_range(0, 4) != 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 49) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_myfilter_cfg
